adpcm_main_sdiv_47s_15ns_32_seq: RTL and testbench
==================================================

// Module: adpcm_main_sdiv_47s_15ns_32_seq
// PURPOSE
//  Sequential signed/unsigned divider: the inverse of the ADPCM datapath's signed x unsigned multiplier.
//  Divides a 47-bit signed dividend by a 15-bit unsigned divisor, one radix-2 restoring step per cycle.
//  Produces a 32-bit signed quotient (C truncation toward zero), a 16-bit signed remainder and status flags.
//  Sits beside the mul cores in adpcm_main; uses a start/ready/done handshake instead of a fixed pipeline.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  din0_WIDTH  47  dividend width, signed
//  din1_WIDTH  15  divisor width, unsigned
//  dout_WIDTH  32  quotient width, signed, saturating
// PORTS
//  clk       in   1           single clock, rising edge
//  reset     in   1           asynchronous, active-low; low = reset
//  ce        in   1           clock enable; low freezes every register, including the FSM and counter
//  start     in   1           request; sampled only when ce=1 and ready=1
//  din0      in   din0_WIDTH  dividend, captured at the accepting edge
//  din1      in   din1_WIDTH  divisor, captured at the accepting edge
//  ready     out  1           high while FSM is in IDLE
//  done      out  1           one-cycle completion pulse
//  dout      out  dout_WIDTH  quotient; held from done until the next completion
//  rem       out  din1_WIDTH+1  signed remainder; held like dout
//  ovf       out  1           quotient saturated; held like dout
//  dz        out  1           divisor was zero; held like dout
// BEHAVIOUR
//  Reset (reset=0, any time, async): state=IDLE, count=0, done=0, dout=0, rem=0, ovf=0, dz=0, ready=1.
//  FSM states:
//   IDLE: on start & ce, latch operands.
//    - Store sign = din0[MSB] and the dividend magnitude |din0| in din0_WIDTH bits; |-2^46| fits unsigned.
//    - Clear the partial remainder.
//    - Go to FIX if din1==0, else go to CALC with count=0.
//   CALC: one step per ce edge.
//    - Shift {prem,mag} left by 1, trial-subtract the divisor, set the quotient bit if no borrow.
//    - prem is din1_WIDTH+1 bits wide.
//    - After din0_WIDTH steps (count==din0_WIDTH-1) go to FIX.
//   FIX, divisor nonzero: q = sign ? -qmag : qmag; rem = sign ? -prem : prem.
//    - Remainder takes the dividend's sign; remainder 0 is never negative.
//    - If q > 2^31-1 or q < -2^31: dout = the saturated bound (0x7FFFFFFF or 0x80000000), ovf=1.
//    - Otherwise dout = q, ovf=0.
//   FIX, divisor zero: dout = sign ? 0x80000000 : 0x7FFFFFFF, rem=0, dz=1, ovf=0.
//   FIX (both cases): register done=1, go to IDLE.
//  Latency, counted from edge E0 that accepts start:
//   - done is high during the cycle after edge E0+din0_WIDTH+1 (E0+48 at defaults).
//   - Divide-by-zero: done is high after edge E0+1.
//   - Back-to-back: the next start is accepted at E0+din0_WIDTH+2. Throughput is 1 op per 49 cycles.
//  done deasserts on the next ce edge. If ce=0 while done=1, done stays high until ce returns.
//  start while ready=0 is ignored, not queued. Operand changes after the accepting edge have no effect.
//  ce=0 in any state: no state change. Latency stretches by exactly the number of ce-low cycles.
//  Outputs dout/rem/ovf/dz change only at the FIX edge and never glitch mid-operation.
// STRUCTURE
//  Package adpcm_main_div_pkg:
//   - FSM state enum {IDLE, CALC, FIX}
//   - localparams for the count width ($clog2(din0_WIDTH)), the Q_MAX and Q_MIN bounds, and prem width.
//  Sub-module adpcm_main_div_step (combinational):
//   - inputs {prem, mag_msb, divisor}
//   - outputs {next_prem, qbit}
//   - instantiated once, driven by the CALC datapath.
//  Top level holds the FSM, count, and the operand/quotient shift registers.
//  Sign-fix and saturation logic live in the top level.
// TESTING
//  1 din0=100, din1=7, start at E0
//    -> done after E0+48, dout=14, rem=2, ovf=0, dz=0; ready low E0+1..E0+48.
//  2 din0=-100, din1=7 -> dout=-14 (0xFFFFFFF2), rem=-2.
//    Also din0=-98, din1=7 -> dout=-14, rem=0, rem not negative.
//  3 din0=-2^46, din1=32767 -> |q|=2147549186 exceeds range, so dout=0x80000000, ovf=1.
//    Also din0=2^46-1, din1=1 -> dout=0x7FFFFFFF, ovf=1.
//  4 din0=-5, din1=0 -> done after E0+1, dout=0x80000000, rem=0, dz=1.
//    Next start with din1=3 clears dz.
//  5 ce held low 5 cycles during CALC -> done at E0+53, same results.
//    start pulsed during CALC -> ignored, one done only.
//  6 reset driven low at E0+20 -> immediate IDLE, all outputs 0, ready=1, no done.
//    Then a fresh 100/7 completes in 48 edges.

Source files
------------

// File: rtl/adpcm_main_div_pkg.sv
// Shared types and constants for the ADPCM sequential signed/unsigned divider.
package adpcm_main_div_pkg;

  // Default operand/result widths of the divider instance used in adpcm_main.
  localparam int DIN0_W = 47;
  localparam int DIN1_W = 15;
  localparam int DOUT_W = 32;

  // Iteration counter width, partial-remainder width and quotient saturation bounds.
  localparam int                CNT_W  = $clog2(DIN0_W);
  localparam int                PREM_W = DIN1_W + 1;
  localparam logic [DOUT_W-1:0] Q_MAX  = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] Q_MIN  = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } div_state_e;

endpackage

// File: rtl/adpcm_main_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and trial-subtract.
module adpcm_main_div_step #(
  parameter int DIV_W  = 15,
  parameter int PREM_W = DIV_W + 1
) (
  input  logic [PREM_W-1:0] prem_i,
  input  logic              mag_msb_i,
  input  logic [DIV_W-1:0]  divisor_i,
  output logic [PREM_W-1:0] next_prem_o,
  output logic              qbit_o
);

  logic [PREM_W:0] shifted;
  logic [PREM_W:0] divisor_ext;
  logic [PREM_W:0] diff;

  assign shifted     = {prem_i, mag_msb_i};
  assign divisor_ext = {{(PREM_W + 1 - DIV_W){1'b0}}, divisor_i};
  assign diff        = shifted - divisor_ext;

  // No borrow means the divisor fits: keep the difference and emit a 1 quotient bit.
  // The partial remainder stays below the divisor, so the low PREM_W bits never lose data.
  assign qbit_o      = (shifted >= divisor_ext);
  assign next_prem_o = qbit_o ? diff[PREM_W-1:0] : shifted[PREM_W-1:0];

endmodule

// File: rtl/adpcm_main_sdiv_47s_15ns_32_seq.sv
// Sequential 47-bit signed / 15-bit unsigned divider, one restoring step per enabled cycle,
// with saturating signed quotient, dividend-signed remainder and start/ready/done handshake.
module adpcm_main_sdiv_47s_15ns_32_seq
  import adpcm_main_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int CW = $clog2(din0_WIDTH);
  localparam int PW = din1_WIDTH + 1;

  // Magnitude limits for a positive / negative quotient, expressed in dividend width.
  localparam logic [din0_WIDTH-1:0] POS_LIM = {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] NEG_LIM = POS_LIM + din0_WIDTH'(1);
  localparam logic [dout_WIDTH-1:0] SAT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SAT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  // ID only tags the instance; it has no functional effect.
  if (ID < 0) begin : g_id_tag_only
  end

  div_state_e              state_q;
  logic [CW-1:0]           count_q;
  logic                    sign_q;
  logic [din0_WIDTH-1:0]   mag_q;
  logic [PW-1:0]           prem_q;
  logic [din1_WIDTH-1:0]   divisor_q;
  logic                    done_q;
  logic [dout_WIDTH-1:0]   dout_q;
  logic [din1_WIDTH:0]     rem_q;
  logic                    ovf_q;
  logic                    dz_q;

  logic [PW-1:0]           step_prem;
  logic                    step_qbit;

  logic                    fix_ovf_d;
  logic [dout_WIDTH-1:0]   fix_dout_d;
  logic [din1_WIDTH:0]     fix_rem_d;

  adpcm_main_div_step #(
    .DIV_W  (din1_WIDTH),
    .PREM_W (PW)
  ) u_step (
    .prem_i      (prem_q),
    .mag_msb_i   (mag_q[din0_WIDTH-1]),
    .divisor_i   (divisor_q),
    .next_prem_o (step_prem),
    .qbit_o      (step_qbit)
  );

  // Sign restore and saturation; after CALC, mag_q holds the quotient magnitude.
  always_comb begin
    fix_ovf_d  = sign_q ? (mag_q > NEG_LIM) : (mag_q > POS_LIM);
    fix_rem_d  = sign_q ? -prem_q : prem_q;
    fix_dout_d = sign_q ? -mag_q[dout_WIDTH-1:0] : mag_q[dout_WIDTH-1:0];
    if (fix_ovf_d) begin
      fix_dout_d = sign_q ? SAT_MIN : SAT_MAX;
    end
  end

  // Control FSM, iteration counter, operand/quotient shift registers and held result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else if (ce) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sign_q    <= din0[din0_WIDTH-1];
            mag_q     <= din0[din0_WIDTH-1] ? -din0 : din0;
            prem_q    <= '0;
            divisor_q <= din1;
            count_q   <= '0;
            state_q   <= (din1 == '0) ? ST_FIX : ST_CALC;
          end
        end
        ST_CALC: begin
          mag_q   <= {mag_q[din0_WIDTH-2:0], step_qbit};
          prem_q  <= step_prem;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(din0_WIDTH - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
          if (divisor_q == '0) begin
            dout_q <= sign_q ? SAT_MIN : SAT_MAX;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b1;
          end else begin
            dout_q <= fix_dout_d;
            rem_q  <= fix_rem_d;
            ovf_q  <= fix_ovf_d;
            dz_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;
  assign ovf   = ovf_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_adpcm_main_sdiv_47s_15ns_32_seq.sv
// Directed testbench for the sequential 47s/15u divider with hand-computed expectations.
module tb_adpcm_main_sdiv_47s_15ns_32_seq;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        start;
  logic [46:0] din0;
  logic [14:0] din1;
  logic        ready;
  logic        done;
  logic [31:0] dout;
  logic [15:0] rem;
  logic        ovf;
  logic        dz;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  adpcm_main_sdiv_47s_15ns_32_seq #(
    .ID         (1),
    .din0_WIDTH (47),
    .din1_WIDTH (15),
    .dout_WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Issue one operation; called #1 after a clock edge with the DUT idle.
  // ce_low_at/pulse_at (0 = unused) drop ce for 5 edges or pulse start mid-operation.
  task automatic run_op(input string name, input logic [46:0] a, input logic [14:0] b,
                        input int ce_low_at, input int pulse_at, output int lat);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din0  = ~a;
    din1  = 15'h1234;
    check_eq({name, ".busy"}, {63'd0, ready}, 64'd0);
    lat = 0;
    while (!done && lat < 200) begin
      if (ce_low_at > 0 && lat == ce_low_at)     ce = 1'b0;
      if (ce_low_at > 0 && lat == ce_low_at + 5) ce = 1'b1;
      if (pulse_at > 0 && lat == pulse_at)       start = 1'b1;
      if (pulse_at > 0 && lat == pulse_at + 1)   start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    ce    = 1'b1;
    start = 1'b0;
    $display("op %s: a=0x%0h b=%0d lat=%0d dout=0x%0h rem=0x%0h ovf=%0b dz=%0b",
             name, a, b, lat, dout, rem, ovf, dz);
  endtask

  // Compare a completed operation and confirm done is a single pulse with the FSM idle.
  task automatic check_op(input string name, input int lat, input int exp_lat,
                          input logic [31:0] exp_dout, input logic [15:0] exp_rem,
                          input logic exp_ovf, input logic exp_dz);
    check_eq({name, ".lat"},  64'(lat), 64'(exp_lat));
    check_eq({name, ".dout"}, {32'd0, dout}, {32'd0, exp_dout});
    check_eq({name, ".rem"},  {48'd0, rem},  {48'd0, exp_rem});
    check_eq({name, ".ovf"},  {63'd0, ovf},  {63'd0, exp_ovf});
    check_eq({name, ".dz"},   {63'd0, dz},   {63'd0, exp_dz});
    check_eq({name, ".rdy"},  {63'd0, ready}, 64'd1);
    @(posedge clk); #1;
    check_eq({name, ".done_fall"}, {63'd0, done}, 64'd0);
    check_eq({name, ".rdy_hold"},  {63'd0, ready}, 64'd1);
    check_eq({name, ".dout_hold"}, {32'd0, dout}, {32'd0, exp_dout});
  endtask

  initial begin
    int          lat;
    int          n_done;
    logic [46:0] a;

    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    #12;
    check_eq("rst.ready", {63'd0, ready}, 64'd1);
    check_eq("rst.done",  {63'd0, done},  64'd0);
    check_eq("rst.dout",  {32'd0, dout},  64'd0);
    check_eq("rst.rem",   {48'd0, rem},   64'd0);
    check_eq("rst.flags", {62'd0, ovf, dz}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic positive and negative divisions
    run_op("p100_7", 47'd100, 15'd7, 0, 0, lat);
    check_op("p100_7", lat, 48, 32'd14, 16'd2, 1'b0, 1'b0);
    a = -47'd100;
    run_op("n100_7", a, 15'd7, 0, 0, lat);
    check_op("n100_7", lat, 48, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0);
    a = -47'd98;
    run_op("n98_7", a, 15'd7, 0, 0, lat);
    check_op("n98_7", lat, 48, 32'hFFFF_FFF2, 16'h0000, 1'b0, 1'b0);

    // Saturation and exact range boundaries
    a = 47'h4000_0000_0000;
    run_op("min_max", a, 15'd32767, 0, 0, lat);
    check_op("min_max", lat, 48, 32'h8000_0000, 16'hFFFE, 1'b1, 1'b0);
    a = 47'h3FFF_FFFF_FFFF;
    run_op("max_1", a, 15'd1, 0, 0, lat);
    check_op("max_1", lat, 48, 32'h7FFF_FFFF, 16'h0000, 1'b1, 1'b0);
    a = 47'h7FFF_8000_0000;
    run_op("qmin_exact", a, 15'd1, 0, 0, lat);
    check_op("qmin_exact", lat, 48, 32'h8000_0000, 16'h0000, 1'b0, 1'b0);
    a = 47'h0000_7FFF_FFFF;
    run_op("qmax_exact", a, 15'd1, 0, 0, lat);
    check_op("qmax_exact", lat, 48, 32'h7FFF_FFFF, 16'h0000, 1'b0, 1'b0);

    // Divide by zero, then a normal op clears dz
    a = -47'd5;
    run_op("dz_n5", a, 15'd0, 0, 0, lat);
    check_op("dz_n5", lat, 1, 32'h8000_0000, 16'h0000, 1'b0, 1'b1);
    run_op("p9_3", 47'd9, 15'd3, 0, 0, lat);
    check_op("p9_3", lat, 48, 32'd3, 16'd0, 1'b0, 1'b0);

    // ce held low 5 cycles during CALC, and a start pulse while busy
    run_op("ce_gap", 47'd100, 15'd7, 10, 0, lat);
    check_op("ce_gap", lat, 53, 32'd14, 16'd2, 1'b0, 1'b0);
    run_op("busy_start", 47'd1000, 15'd9, 0, 20, lat);
    check_op("busy_start", lat, 48, 32'd111, 16'd1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation
    din0  = 47'd100;
    din1  = 15'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_eq("mid_rst.ready", {63'd0, ready}, 64'd1);
    check_eq("mid_rst.done",  {63'd0, done},  64'd0);
    check_eq("mid_rst.dout",  {32'd0, dout},  64'd0);
    check_eq("mid_rst.rem",   {48'd0, rem},   64'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_eq("mid_rst.no_done", 64'(n_done), 64'd0);
    $display("op mid_rst: reset during CALC, dones after reset=%0d", n_done);
    run_op("post_rst", 47'd100, 15'd7, 0, 0, lat);
    check_op("post_rst", lat, 48, 32'd14, 16'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
